display: RTL and testbench

- Registered two-digit seven-segment driver for the craps dice game.
- Captures the two 3-bit die values only on cycles where clock_en is high, then drives HEX0 (die 1) and HEX1 (die 2).
- Outputs are active-low, matching the board's common-anode displays.
- Sits between the dice/roller logic and the HEX0/HEX1 pins.

---
 rtl/craps_pkg.sv | 15 +
 rtl/display_if.sv | 14 +
 rtl/seg7_decode.sv | 16 +
 rtl/display.sv | 39 +++
 tb/tb_display.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/craps_pkg.sv
// Shared constants and types for the craps dice seven-segment display.
// Patterns are stored active-low as {g,f,e,d,c,b,a}; inversion happens in the decoder.
package craps_pkg;

  typedef logic [2:0] die_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Values 0 and 7 are not legal dice faces, so they show a dash.
  localparam logic [6:0] SEG_PATTERN [8] = '{
    SEG_DASH, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, SEG_DASH
  };

endpackage

// File: rtl/display_if.sv
// Bus between the dice/roller logic and the two-digit display driver.
interface display_if;
  import craps_pkg::*;

  logic       clock_en;
  die_t       dice1;
  die_t       dice2;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  modport master (output clock_en, dice1, dice2, input HEX0, HEX1);
  modport slave  (input clock_en, dice1, dice2, output HEX0, HEX1);

endinterface

// File: rtl/seg7_decode.sv
// Combinational die value to seven-segment pattern, with selectable polarity.
module seg7_decode
  import craps_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  die_t       value,
  output logic [6:0] segments
);

  logic [6:0] pattern_low;

  assign pattern_low = SEG_PATTERN[value];
  assign segments    = ACTIVE_LOW ? pattern_low : ~pattern_low;

endmodule

// File: rtl/display.sv
// Registered two-digit die display: both digits captured together on clock_en.
// Outputs stay blank from reset until the first capture.
module display
  import craps_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  display_if.slave   bus
);

  localparam logic [6:0] BLANK = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic [6:0] dec0;
  logic [6:0] dec1;
  logic [6:0] hex0_q;
  logic [6:0] hex1_q;
  logic       valid;

  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec0 (.value(bus.dice1), .segments(dec0));
  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec1 (.value(bus.dice2), .segments(dec1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hex0_q <= BLANK;
      hex1_q <= BLANK;
      valid  <= 1'b0;
    end else if (bus.clock_en) begin
      hex0_q <= dec0;
      hex1_q <= dec1;
      valid  <= 1'b1;
    end
  end

  assign bus.HEX0 = valid ? hex0_q : BLANK;
  assign bus.HEX1 = valid ? hex1_q : BLANK;

endmodule

// File: tb/tb_display.sv
// Directed bench for the display driver: board polarity plus an inverted-polarity instance.
module tb_display;
  import craps_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  display_if bus_n ();
  display_if bus_p ();

  display #(.ACTIVE_LOW(1'b1)) dut_n (.clock(clock), .reset(reset), .bus(bus_n.slave));
  display #(.ACTIVE_LOW(1'b0)) dut_p (.clock(clock), .reset(reset), .bus(bus_p.slave));

  always #5 clock = ~clock;

  logic [6:0] track0 [8] = '{7'h3F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h3F};
  logic [6:0] track1 [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h3F, 7'h3F};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus_n.clock_en = 1'b0; bus_n.dice1 = 3'd3; bus_n.dice2 = 3'd4;
    bus_p.clock_en = 1'b0; bus_p.dice1 = 3'd3; bus_p.dice2 = 3'd4;
    reset = 1'b1;
    #2;
    vectors++;
    if (bus_n.HEX0 !== 7'h7F || bus_n.HEX1 !== 7'h7F) begin
      miscompares++;
      $display("FAIL reset_assert HEX0=%h HEX1=%h expected 7f 7f", bus_n.HEX0, bus_n.HEX1);
    end
    step();
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus_n.HEX0 !== 7'h7F || bus_n.HEX1 !== 7'h7F) begin
        miscompares++;
        $display("FAIL reset_idle[%0d] HEX0=%h HEX1=%h expected 7f 7f", i, bus_n.HEX0, bus_n.HEX1);
      end
      vectors++;
      if (bus_p.HEX0 !== 7'h00 || bus_p.HEX1 !== 7'h00) begin
        miscompares++;
        $display("FAIL reset_idle_inv[%0d] HEX0=%h HEX1=%h expected 00 00", i, bus_p.HEX0, bus_p.HEX1);
      end
    end
  endtask

  task automatic test_hold_disabled();
    bus_n.clock_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_n.dice1 = 3'(i);
      bus_n.dice2 = 3'(i + 1);
      step();
      vectors++;
      if (bus_n.HEX0 !== 7'h7F || bus_n.HEX1 !== 7'h7F) begin
        miscompares++;
        $display("FAIL hold_disabled[%0d] HEX0=%h HEX1=%h expected 7f 7f", i, bus_n.HEX0, bus_n.HEX1);
      end
    end
  endtask

  task automatic test_tracking();
    bus_n.clock_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_n.dice1 = 3'(i);
      bus_n.dice2 = 3'(i + 1);
      step();
      vectors++;
      if (bus_n.HEX0 !== track0[i] || bus_n.HEX1 !== track1[i]) begin
        miscompares++;
        $display("FAIL tracking[%0d] HEX0=%h HEX1=%h expected %h %h",
                 i, bus_n.HEX0, bus_n.HEX1, track0[i], track1[i]);
      end
    end
  endtask

  task automatic test_freeze();
    bus_n.clock_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_n.dice1 = 3'(i + 1);
      bus_n.dice2 = 3'(i + 3);
      step();
      vectors++;
      if (bus_n.HEX0 !== 7'h3F || bus_n.HEX1 !== 7'h3F) begin
        miscompares++;
        $display("FAIL freeze[%0d] HEX0=%h HEX1=%h expected 3f 3f", i, bus_n.HEX0, bus_n.HEX1);
      end
    end
  endtask

  task automatic test_midrun_reset();
    bus_n.clock_en = 1'b1; bus_n.dice1 = 3'd5; bus_n.dice2 = 3'd2;
    step();
    vectors++;
    if (bus_n.HEX0 !== 7'h12 || bus_n.HEX1 !== 7'h24) begin
      miscompares++;
      $display("FAIL midrun_capture HEX0=%h HEX1=%h expected 12 24", bus_n.HEX0, bus_n.HEX1);
    end
    bus_n.clock_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus_n.HEX0 !== 7'h7F || bus_n.HEX1 !== 7'h7F) begin
      miscompares++;
      $display("FAIL midrun_reset HEX0=%h HEX1=%h expected 7f 7f", bus_n.HEX0, bus_n.HEX1);
    end
    #1 reset = 1'b0;
    bus_n.dice1 = 3'd6; bus_n.dice2 = 3'd1;
    step();
    vectors++;
    if (bus_n.HEX0 !== 7'h7F || bus_n.HEX1 !== 7'h7F) begin
      miscompares++;
      $display("FAIL post_reset_blank HEX0=%h HEX1=%h expected 7f 7f", bus_n.HEX0, bus_n.HEX1);
    end
    bus_n.clock_en = 1'b1;
    step();
    vectors++;
    if (bus_n.HEX0 !== 7'h02 || bus_n.HEX1 !== 7'h79) begin
      miscompares++;
      $display("FAIL post_reset_capture HEX0=%h HEX1=%h expected 02 79", bus_n.HEX0, bus_n.HEX1);
    end
    bus_n.clock_en = 1'b0;
  endtask

  task automatic test_polarity();
    bus_p.clock_en = 1'b1; bus_p.dice1 = 3'd1; bus_p.dice2 = 3'd6;
    step();
    bus_p.clock_en = 1'b0;
    vectors++;
    if (bus_p.HEX0 !== 7'h06 || bus_p.HEX1 !== 7'h7D) begin
      miscompares++;
      $display("FAIL polarity_capture HEX0=%h HEX1=%h expected 06 7d", bus_p.HEX0, bus_p.HEX1);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus_p.HEX0 !== 7'h00 || bus_p.HEX1 !== 7'h00) begin
      miscompares++;
      $display("FAIL polarity_reset HEX0=%h HEX1=%h expected 00 00", bus_p.HEX0, bus_p.HEX1);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_disabled();
    test_tracking();
    test_freeze();
    test_midrun_reset();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
